// File: rtl/alu_operand_stage_if.sv
// Signal bundle between the ID stage, the forwarding sources and the ALU operand stage.
// Handshake: an instruction transfers on a rising edge where id_valid && id_ready.
interface alu_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FUNC_W = 6
);
  logic              id_valid;
  logic              id_ready;
  logic [FUNC_W-1:0] id_func;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_shamt;
  logic              id_use_imm;
  logic              id_use_shamt;
  logic [REG_AW-1:0] id_rd_addr;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              ex_stall;
  logic              exmem_reg_write;
  logic [REG_AW-1:0] exmem_rd_addr;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_reg_write;
  logic [REG_AW-1:0] memwb_rd_addr;
  logic [DATA_W-1:0] memwb_result;
  logic              ex_valid;
  logic [FUNC_W-1:0] ex_func;
  logic [DATA_W-1:0] ex_op_0;
  logic [DATA_W-1:0] ex_op_1;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;

  modport master (
    output id_valid, id_func, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_use_imm, id_use_shamt, id_rd_addr, id_reg_write,
           id_mem_read, flush, ex_stall, exmem_reg_write, exmem_rd_addr,
           exmem_result, memwb_reg_write, memwb_rd_addr, memwb_result,
    input  id_ready, ex_valid, ex_func, ex_op_0, ex_op_1, ex_rd_addr,
           ex_reg_write, ex_mem_read
  );

  modport slave (
    input  id_valid, id_func, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
           id_imm, id_shamt, id_use_imm, id_use_shamt, id_rd_addr, id_reg_write,
           id_mem_read, flush, ex_stall, exmem_reg_write, exmem_rd_addr,
           exmem_result, memwb_reg_write, memwb_rd_addr, memwb_result,
    output id_ready, ex_valid, ex_func, ex_op_0, ex_op_1, ex_rd_addr,
           ex_reg_write, ex_mem_read
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX register ahead of the ALU: stores the decoded instruction, resolves
// EX/MEM and MEM/WB forwarding, selects operands and raises load-use stalls.
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FUNC_W = 6
) (
  input logic                clk,
  input logic                rst_n,
  alu_operand_stage_if.slave bus
);

  logic              valid_q;
  logic [FUNC_W-1:0] func_q;
  logic [REG_AW-1:0] rs_addr_q;
  logic [REG_AW-1:0] rt_addr_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [4:0]        shamt_q;
  logic              use_imm_q;
  logic              use_shamt_q;
  logic [REG_AW-1:0] rd_addr_q;
  logic              reg_write_q;
  logic              mem_read_q;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic [DATA_W-1:0] op_0;
  logic [DATA_W-1:0] op_1;
  logic              hazard;
  logic              ready;

  // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is never forwarded.
  always_comb begin
    fwd_rs = rs_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd_addr == rs_addr_q) && (rs_addr_q != '0))
      fwd_rs = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd_addr == rs_addr_q) && (rs_addr_q != '0))
      fwd_rs = bus.memwb_result;

    fwd_rt = rt_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd_addr == rt_addr_q) && (rt_addr_q != '0))
      fwd_rt = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd_addr == rt_addr_q) && (rt_addr_q != '0))
      fwd_rt = bus.memwb_result;
  end

  always_comb begin
    op_0 = fwd_rs;
    op_1 = fwd_rt;
    if (use_shamt_q) begin
      op_0 = fwd_rt;
      op_1 = {{(DATA_W-5){1'b0}}, shamt_q};
    end else if (use_imm_q) begin
      op_1 = imm_q;
    end
  end

  // rt is compared even for immediate forms: cheaper than decoding which operands are read.
  assign hazard = valid_q && mem_read_q && (rd_addr_q != '0) &&
                  ((rd_addr_q == bus.id_rs_addr) || (rd_addr_q == bus.id_rt_addr));
  assign ready  = !bus.ex_stall && !hazard && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      func_q      <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      use_imm_q   <= 1'b0;
      use_shamt_q <= 1'b0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (bus.ex_stall) begin
      // Refresh so results retiring from MEM/WB during the stall are not lost.
      rs_data_q <= fwd_rs;
      rt_data_q <= fwd_rt;
    end else if (bus.id_valid && ready) begin
      valid_q     <= 1'b1;
      func_q      <= bus.id_func;
      rs_addr_q   <= bus.id_rs_addr;
      rt_addr_q   <= bus.id_rt_addr;
      rs_data_q   <= bus.id_rs_data;
      rt_data_q   <= bus.id_rt_data;
      imm_q       <= bus.id_imm;
      shamt_q     <= bus.id_shamt;
      use_imm_q   <= bus.id_use_imm;
      use_shamt_q <= bus.id_use_shamt;
      rd_addr_q   <= bus.id_rd_addr;
      reg_write_q <= bus.id_reg_write;
      mem_read_q  <= bus.id_mem_read;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.id_ready     = ready;
  assign bus.ex_valid     = valid_q;
  assign bus.ex_func      = func_q;
  assign bus.ex_op_0      = op_0;
  assign bus.ex_op_1      = op_1;
  assign bus.ex_rd_addr   = rd_addr_q;
  assign bus.ex_reg_write = reg_write_q & valid_q;
  assign bus.ex_mem_read  = mem_read_q & valid_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: forwarding, operand select, load-use,
// stall refresh, flush and asynchronous reset, against hand-computed values.
module tb_alu_operand_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_operand_stage_if #(.DATA_W(32), .REG_AW(5), .FUNC_W(6)) bus ();

  alu_operand_stage #(.DATA_W(32), .REG_AW(5), .FUNC_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_id(input logic [5:0] func, input logic [4:0] rs, input logic [31:0] rsd,
                          input logic [4:0] rt, input logic [31:0] rtd, input logic [31:0] imm,
                          input logic [4:0] shamt, input logic use_imm, input logic use_shamt,
                          input logic [4:0] rd, input logic rw, input logic mr);
    bus.id_valid     = 1'b1;
    bus.id_func      = func;
    bus.id_rs_addr   = rs;
    bus.id_rs_data   = rsd;
    bus.id_rt_addr   = rt;
    bus.id_rt_data   = rtd;
    bus.id_imm       = imm;
    bus.id_shamt     = shamt;
    bus.id_use_imm   = use_imm;
    bus.id_use_shamt = use_shamt;
    bus.id_rd_addr   = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
  endtask

  task automatic clear_fwd();
    bus.exmem_reg_write = 1'b0;
    bus.exmem_rd_addr   = '0;
    bus.exmem_result    = '0;
    bus.memwb_reg_write = 1'b0;
    bus.memwb_rd_addr   = '0;
    bus.memwb_result    = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive_id(6'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.id_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.ex_stall = 1'b0;
    clear_fwd();

    #3;
    chk("reset_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("reset_func", {26'b0, bus.ex_func}, 32'h0);
    chk("reset_op0", bus.ex_op_0, 32'h0);
    chk("reset_op1", bus.ex_op_1, 32'h0);
    chk("reset_rd", {27'b0, bus.ex_rd_addr}, 32'h0);
    chk("reset_rw", {31'b0, bus.ex_reg_write}, 32'h0);
    chk("reset_mr", {31'b0, bus.ex_mem_read}, 32'h0);
    chk("reset_ready", {31'b0, bus.id_ready}, 32'h1);
    rst_n = 1'b1;

    // Plain register form, then an immediate form back-to-back
    drive_id(6'h21, 5'd1, 32'h100, 5'd2, 32'h200, 32'h0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    step();
    chk("a_valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("a_func", {26'b0, bus.ex_func}, 32'h21);
    chk("a_op0", bus.ex_op_0, 32'h100);
    chk("a_op1", bus.ex_op_1, 32'h200);
    chk("a_rd", {27'b0, bus.ex_rd_addr}, 32'h3);
    chk("a_rw", {31'b0, bus.ex_reg_write}, 32'h1);
    chk("a_mr", {31'b0, bus.ex_mem_read}, 32'h0);
    drive_id(6'h08, 5'd4, 32'hA, 5'd6, 32'h999, 32'hFFFF_FFF0, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    step();
    chk("b_func", {26'b0, bus.ex_func}, 32'h08);
    chk("b_op0", bus.ex_op_0, 32'hA);
    chk("b_op1_imm", bus.ex_op_1, 32'hFFFF_FFF0);

    // Forwarding priority on stored rs=3
    drive_id(6'h20, 5'd3, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
    step();
    bus.id_valid = 1'b0;
    bus.exmem_reg_write = 1'b1; bus.exmem_rd_addr = 5'd3; bus.exmem_result = 32'h11;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd_addr = 5'd3; bus.memwb_result = 32'h22;
    #1;
    chk("fwd_exmem_wins", bus.ex_op_0, 32'h11);
    bus.exmem_reg_write = 1'b0;
    #1;
    chk("fwd_memwb", bus.ex_op_0, 32'h22);
    bus.memwb_reg_write = 1'b0;
    #1;
    chk("fwd_none", bus.ex_op_0, 32'h0);
    step();
    chk("bubble_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("bubble_rw_gated", {31'b0, bus.ex_reg_write}, 32'h0);

    // Register 0 never forwarded
    bus.exmem_reg_write = 1'b1; bus.exmem_rd_addr = 5'd0; bus.exmem_result = 32'h11;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd_addr = 5'd0; bus.memwb_result = 32'h22;
    drive_id(6'h20, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
    step();
    chk("r0_op0", bus.ex_op_0, 32'h0);
    chk("r0_op1", bus.ex_op_1, 32'h0);
    clear_fwd();

    // Load-use: load to r5 followed by a reader of r5 via rt
    drive_id(6'h23, 5'd1, 32'h40, 5'd0, 32'h0, 32'h4, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    chk("load_mr", {31'b0, bus.ex_mem_read}, 32'h1);
    drive_id(6'h21, 5'd2, 32'h3, 5'd5, 32'h0BAD, 32'h0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
    #1;
    chk("lu_ready_low", {31'b0, bus.id_ready}, 32'h0);
    step();
    chk("lu_bubble_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("lu_bubble_mr", {31'b0, bus.ex_mem_read}, 32'h0);
    chk("lu_ready_back", {31'b0, bus.id_ready}, 32'h1);
    step();
    bus.id_valid = 1'b0;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd_addr = 5'd5; bus.memwb_result = 32'hDEAD_BEEF;
    #1;
    chk("lu_valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("lu_op0", bus.ex_op_0, 32'h3);
    chk("lu_op1_fwd", bus.ex_op_1, 32'hDEAD_BEEF);
    chk("lu_rd", {27'b0, bus.ex_rd_addr}, 32'h9);
    clear_fwd();

    // Stall refresh: MEM/WB writes r7 only in the first stalled cycle
    drive_id(6'h22, 5'd1, 32'h2, 5'd7, 32'h1, 32'h0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0);
    step();
    drive_id(6'h25, 5'd8, 32'h8, 5'd9, 32'h9, 32'h0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0);
    bus.ex_stall = 1'b1;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd_addr = 5'd7; bus.memwb_result = 32'h55;
    #1;
    chk("stall_ready_c1", {31'b0, bus.id_ready}, 32'h0);
    step();
    clear_fwd();
    #1;
    chk("stall_ready_c2", {31'b0, bus.id_ready}, 32'h0);
    chk("stall_hold_valid", {31'b0, bus.ex_valid}, 32'h1);
    step();
    chk("stall_ready_c3", {31'b0, bus.id_ready}, 32'h0);
    step();
    bus.ex_stall = 1'b0;
    bus.id_valid = 1'b0;
    #1;
    chk("stall_op1_kept", bus.ex_op_1, 32'h55);
    chk("stall_op0", bus.ex_op_0, 32'h2);
    chk("stall_func", {26'b0, bus.ex_func}, 32'h22);
    chk("stall_rd", {27'b0, bus.ex_rd_addr}, 32'hA);
    step();

    // Flush overrides a simultaneous stall
    drive_id(6'h24, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
    step();
    chk("pre_flush_rw", {31'b0, bus.ex_reg_write}, 32'h1);
    bus.id_valid = 1'b0;
    bus.flush    = 1'b1;
    bus.ex_stall = 1'b1;
    #1;
    chk("flush_ready", {31'b0, bus.id_ready}, 32'h0);
    step();
    chk("flush_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("flush_rw", {31'b0, bus.ex_reg_write}, 32'h0);
    bus.flush    = 1'b0;
    bus.ex_stall = 1'b0;

    // Shift form beats use_imm
    drive_id(6'h00, 5'd13, 32'h7777, 5'd12, 32'h80, 32'h1234, 5'd4, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0);
    step();
    bus.id_valid = 1'b0;
    chk("shift_op0", bus.ex_op_0, 32'h80);
    chk("shift_op1", bus.ex_op_1, 32'h4);

    // Asynchronous reset between edges while holding a live instruction
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", {31'b0, bus.ex_valid}, 32'h0);
    chk("areset_op0", bus.ex_op_0, 32'h0);
    chk("areset_op1", bus.ex_op_1, 32'h0);
    chk("areset_func", {26'b0, bus.ex_func}, 32'h0);
    chk("areset_rd", {27'b0, bus.ex_rd_addr}, 32'h0);
    chk("areset_rw", {31'b0, bus.ex_reg_write}, 32'h0);
    rst_n = 1'b1;
    drive_id(6'h2A, 5'd1, 32'h31, 5'd2, 32'h32, 32'h0, 5'd0, 1'b0, 1'b0, 5'd15, 1'b1, 1'b0);
    #1;
    chk("post_reset_pre_edge", {31'b0, bus.ex_valid}, 32'h0);
    step();
    bus.id_valid = 1'b0;
    chk("post_reset_valid", {31'b0, bus.ex_valid}, 32'h1);
    chk("post_reset_op0", bus.ex_op_0, 32'h31);
    chk("post_reset_op1", bus.ex_op_1, 32'h32);
    chk("post_reset_rd", {27'b0, bus.ex_rd_addr}, 32'hF);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
